// File: rtl/z80_bus_arbiter.sv
// Two-master arbiter for the shared Z80 memory/IO bus: CPU (requester 0) and aux master (requester 1).
// Optional forced-completion watchdog enabled by defining ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_dat,
    output logic [DATA_W-1:0] o_cpu_dat,
    output logic              o_cpu_ack,
    input  logic              i_aux_cs,
    input  logic              i_aux_we,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [DATA_W-1:0] i_aux_dat,
    output logic [DATA_W-1:0] o_aux_dat,
    output logic              o_aux_ack,
    output logic              o_mem_cs,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_dat,
    input  logic [DATA_W-1:0] i_mem_dat,
    input  logic              i_mem_ack,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_AUX = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_aux;       // 1 when aux held the most recent grant
    logic   last_aux_nxt;
    logic   owner_cs;
    logic   tmo_raw;
    logic   tmo_fire;
    logic   done;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Grant-cycle counter; IDLE always precedes a grant, so it is clear on grant entry
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT-th grant cycle; a slave ack in the same cycle takes precedence
    assign tmo_raw = (state != IDLE) && !i_mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_raw        = 1'b0;
`endif

    // State and round-robin pointer registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            last_aux <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_aux <= last_aux_nxt;
        end
    end

    // Owner request and completion qualifiers; a dropped cs is an abort and never completes
    always_comb begin
        owner_cs = 1'b0;
        case (state)
            GNT_CPU: owner_cs = i_cpu_cs;
            GNT_AUX: owner_cs = i_aux_cs;
            default: owner_cs = 1'b0;
        endcase
        tmo_fire = owner_cs && tmo_raw;
        done     = owner_cs && (i_mem_ack || tmo_fire);
    end

    // Next-state arbitration and owner-muxed bus outputs
    always_comb begin
        state_nxt    = state;
        last_aux_nxt = last_aux;
        o_mem_cs     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_dat    = '0;
        o_cpu_ack    = 1'b0;
        o_cpu_dat    = '0;
        o_aux_ack    = 1'b0;
        o_aux_dat    = '0;
        o_grant      = 2'b00;
        o_timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (i_cpu_cs && i_aux_cs) begin
                    if ((FIXED_PRIO != 0) || last_aux) begin
                        state_nxt    = GNT_CPU;
                        last_aux_nxt = 1'b0;
                    end else begin
                        state_nxt    = GNT_AUX;
                        last_aux_nxt = 1'b1;
                    end
                end else if (i_cpu_cs) begin
                    state_nxt    = GNT_CPU;
                    last_aux_nxt = 1'b0;
                end else if (i_aux_cs) begin
                    state_nxt    = GNT_AUX;
                    last_aux_nxt = 1'b1;
                end
            end
            GNT_CPU: begin
                o_mem_cs   = 1'b1;
                o_mem_we   = i_cpu_we;
                o_mem_addr = i_cpu_addr;
                o_mem_dat  = i_cpu_dat;
                o_grant    = 2'b01;
                o_cpu_ack  = done;
                o_cpu_dat  = tmo_fire ? {DATA_W{1'b1}} : i_mem_dat;
                o_timeout  = tmo_fire;
                if (!i_cpu_cs || done) begin
                    state_nxt = IDLE;
                end
            end
            GNT_AUX: begin
                o_mem_cs   = 1'b1;
                o_mem_we   = i_aux_we;
                o_mem_addr = i_aux_addr;
                o_mem_dat  = i_aux_dat;
                o_grant    = 2'b10;
                o_aux_ack  = done;
                o_aux_dat  = tmo_fire ? {DATA_W{1'b1}} : i_mem_dat;
                o_timeout  = tmo_fire;
                if (!i_aux_cs || done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
